// File: rtl/hazard_scheduler.sv
// hazard_scheduler: pipeline hazard controller for the 5-stage 64-bit core.
// Produces execute-stage forwarding selects, load-use stalls, branch
// flushes, multi-cycle mul/div sequencing and stall/flush event counters.
//
// Handshake note: there is no valid/ready pair here. MulDivE acts as a
// level "request" from Execute. The op is accepted in IDLE on the cycle
// MulDivE=1 and PCSrcE=0. It is held (StallE=1) for MDIV_CYCLES cycles.
// Completion is a single-cycle MulDivDoneE pulse on the following cycle,
// during which the Execute register is released.
module hazard_scheduler #(
  parameter int MDIV_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MulDivE,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MulDivBusy,
  output logic             MulDivDoneE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic [1:0]       MdStateDbg
);

  // Forwarding select encodings seen by the execute-stage source muxes.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Counter preload: one stall cycle is spent in IDLE on acceptance and one
  // more on the BUSY cycle that sees cnt==0, so the load is MDIV_CYCLES-2.
  localparam logic [3:0] CNT_LOAD = 4'(MDIV_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } md_state_t;

  md_state_t  r_state;
  logic [3:0] r_cnt;

  logic w_rst_n;
  logic w_fwd_a_mem;
  logic w_fwd_a_wb;
  logic w_fwd_b_mem;
  logic w_fwd_b_wb;
  logic w_lw_stall;
  logic w_md_accept;
  logic w_md_stall;
  logic w_stall;
  logic w_flush_d;
  logic w_flush_e;

  assign w_rst_n = rst;

  // Forwarding source selection; memory stage is younger so it wins.
  always_comb begin
    w_fwd_a_mem = RegWriteM && (RD_M != 5'd0) && (RD_M == Rs1_E);
    w_fwd_a_wb  = RegWriteW && (RD_W != 5'd0) && (RD_W == Rs1_E);
    w_fwd_b_mem = RegWriteM && (RD_M != 5'd0) && (RD_M == Rs2_E);
    w_fwd_b_wb  = RegWriteW && (RD_W != 5'd0) && (RD_W == Rs2_E);

    ForwardA_E = FWD_RF;
    if (w_fwd_a_mem)     ForwardA_E = FWD_MEM;
    else if (w_fwd_a_wb) ForwardA_E = FWD_WB;

    ForwardB_E = FWD_RF;
    if (w_fwd_b_mem)     ForwardB_E = FWD_MEM;
    else if (w_fwd_b_wb) ForwardB_E = FWD_WB;
  end

  // Load-use detection and mul/div stall request; all gated off in reset.
  always_comb begin
    w_lw_stall  = w_rst_n && ResultSrcE && (RD_E != 5'd0) &&
                  ((RD_E == Rs1_D) || (RD_E == Rs2_D));
    // A taken branch squashes the mul/div in Execute, so it is not accepted.
    w_md_accept = w_rst_n && (r_state == S_IDLE) && MulDivE && !PCSrcE;
    w_md_stall  = w_md_accept || (w_rst_n && (r_state == S_BUSY));
    w_stall     = w_lw_stall || w_md_stall;
    w_flush_d   = w_rst_n && PCSrcE;
    // A held Execute register must keep its op, so no bubble while mdStall.
    w_flush_e   = w_rst_n && (w_lw_stall || PCSrcE) && !w_md_stall;
  end

  assign StallF      = w_stall;
  assign StallD      = w_stall;
  assign StallE      = w_md_stall;
  assign FlushD      = w_flush_d;
  assign FlushE      = w_flush_e;
  assign MulDivBusy  = w_rst_n && (r_state == S_BUSY);
  assign MulDivDoneE = w_rst_n && (r_state == S_DONE);
  assign MdStateDbg  = r_state;

  // Mul/div sequencer: IDLE -> BUSY (count down) -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_md_accept) begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          // The op leaves Execute this cycle; never re-arm on it.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Wrapping performance counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (w_stall) begin
        StallCount <= StallCount + CNT_W'(1);
      end
      if (w_flush_d || w_flush_e) begin
        FlushCount <= FlushCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed testbench for hazard_scheduler (MDIV_CYCLES=4, CNT_W=4).
module tb_hazard_scheduler;

  localparam int MDIV = 4;
  localparam int CW   = 4;

  logic          clk;
  logic          rst;
  logic [4:0]    Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic          RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivE;
  logic [1:0]    ForwardA_E, ForwardB_E;
  logic          StallF, StallD, StallE, FlushD, FlushE;
  logic          MulDivBusy, MulDivDoneE;
  logic [CW-1:0] StallCount, FlushCount;
  logic [1:0]    MdStateDbg;

  int n_pass;
  int n_total;
  logic [CW-1:0] exp_stall;
  logic [CW-1:0] exp_flush;

  hazard_scheduler #(.MDIV_CYCLES(MDIV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE),
    .MulDivBusy(MulDivBusy), .MulDivDoneE(MulDivDoneE),
    .StallCount(StallCount), .FlushCount(FlushCount),
    .MdStateDbg(MdStateDbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs/outputs settle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    // order: StallF StallD StallE FlushD FlushE MulDivBusy MulDivDoneE
    chk(tag, {25'd0, StallF, StallD, StallE, FlushD, FlushE, MulDivBusy, MulDivDoneE},
        {25'd0, exp});
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_stallcnt"}, {28'd0, StallCount}, {28'd0, exp_stall});
    chk({tag, "_flushcnt"}, {28'd0, FlushCount}, {28'd0, exp_flush});
  endtask

  task automatic clear_inputs();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0;
    RD_E = 0; RD_M = 0; RD_W = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MulDivE = 0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    exp_stall = '0; exp_flush = '0;
    clear_inputs();
    rst = 1'b0;

    // Reset: outputs forced low even with every hazard source asserted.
    PCSrcE = 1; MulDivE = 1; ResultSrcE = 1; RD_E = 7; Rs1_D = 7;
    tick(); tick();
    chk_ctl("rst_ctl", 7'b0000000);
    chk_cnt("rst");
    chk("rst_state", {30'd0, MdStateDbg}, 32'd0);
    RegWriteM = 1; RD_M = 3; Rs1_E = 3;
    #1 chk("rst_fwd_comb", {30'd0, ForwardA_E}, 32'd2);
    clear_inputs();
    rst = 1'b1;
    #1 chk_ctl("idle_ctl", 7'b0000000);

    // Forwarding priority.
    RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; Rs1_E = 5; Rs2_E = 5;
    #1 chk("fwd_mem_a", {30'd0, ForwardA_E}, 32'd2);
    chk("fwd_mem_b", {30'd0, ForwardB_E}, 32'd2);
    RegWriteM = 0;
    #1 chk("fwd_wb_a", {30'd0, ForwardA_E}, 32'd1);
    chk("fwd_wb_b", {30'd0, ForwardB_E}, 32'd1);
    RegWriteM = 1; RD_M = 0; RD_W = 0; Rs1_E = 0; Rs2_E = 0;
    #1 chk("fwd_x0_a", {30'd0, ForwardA_E}, 32'd0);
    chk("fwd_x0_b", {30'd0, ForwardB_E}, 32'd0);
    RD_M = 3; RD_W = 4; Rs1_E = 3; Rs2_E = 4;
    #1 chk("fwd_mix_a", {30'd0, ForwardA_E}, 32'd2);
    chk("fwd_mix_b", {30'd0, ForwardB_E}, 32'd1);
    RegWriteW = 0;
    #1 chk("fwd_nowb_b", {30'd0, ForwardB_E}, 32'd0);
    clear_inputs();

    // Load-use on Rs2_D: one stall cycle with a bubble.
    ResultSrcE = 1; RD_E = 7; Rs2_D = 7;
    #1 chk_ctl("lu_ctl", 7'b1100100);
    tick();
    exp_stall = 1; exp_flush = 1;
    chk_cnt("lu");
    RD_E = 0; Rs2_D = 0;
    #1 chk_ctl("lu_x0_ctl", 7'b0000000);
    tick();
    chk_cnt("lu_x0");
    clear_inputs();

    // Branch flush.
    PCSrcE = 1;
    #1 chk_ctl("br_ctl", 7'b0001100);
    tick();
    exp_flush = 2;
    chk_cnt("br");
    MulDivE = 1;
    #1 chk_ctl("br_md_ctl", 7'b0001100);
    tick();
    exp_flush = 3;
    chk("br_md_state", {30'd0, MdStateDbg}, 32'd0);
    chk_ctl("br_md_after", 7'b0001100);
    clear_inputs();
    #1 chk_ctl("br_md_clear", 7'b0000000);

    // Mul/div held from cycle 0: StallE cycles 0-3, Busy 1-3, Done at 4.
    MulDivE = 1;
    #1 chk_ctl("md_c0", 7'b1110000);
    tick();
    chk_ctl("md_c1", 7'b1110010);
    tick();
    // A branch arriving while Execute is held flushes Decode only.
    PCSrcE = 1;
    #1 chk_ctl("md_c2_br", 7'b1111010);
    tick();
    PCSrcE = 0;
    #1 chk_ctl("md_c3", 7'b1110010);
    tick();
    chk_ctl("md_c4_done", 7'b0000001);
    exp_stall = 5; exp_flush = 4;
    chk_cnt("md_c4");
    tick();
    MulDivE = 0;
    #1 chk_ctl("md_c5", 7'b0000000);
    chk("md_c5_state", {30'd0, MdStateDbg}, 32'd0);
    chk_cnt("md_c5");

    // Reset in cycle 2 of a mul/div aborts it.
    MulDivE = 1;
    tick();
    tick();
    chk_ctl("rmd_c2", 7'b1110010);
    rst = 1'b0;
    #1 chk_ctl("rmd_rst_ctl", 7'b0000000);
    tick();
    exp_stall = 0; exp_flush = 0;
    chk_cnt("rmd_rst");
    chk("rmd_state", {30'd0, MdStateDbg}, 32'd0);
    rst = 1'b1; MulDivE = 0;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rmd_no_done", {31'd0, MulDivDoneE}, 32'd0);
      tick();
    end
    chk_cnt("rmd_after");

    // Counter wrap at CNT_W=4 using a sustained load-use stall.
    ResultSrcE = 1; RD_E = 9; Rs1_D = 9;
    for (int i = 0; i < 15; i++) tick();
    exp_stall = 4'd15; exp_flush = 4'd15;
    chk_cnt("wrap15");
    tick();
    exp_stall = 4'd0; exp_flush = 4'd0;
    chk_cnt("wrap0");
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
